req_grant_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource among 9 requesters.
//   - Registers a one-hot grant vector and its 4-bit encoded index: 1..9 = requester 0..8, 0 = none.
//   - The encoded index uses the same code the 9-to-4 one-hot encoder produces.
//   - Sits between request lines and the shared datapath; downstream logic consumes gnt_id directly.
//   - Provides grant hold, rotating priority, and a hold-timeout watchdog.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 29 ++
 rtl/req_grant_arbiter.sv | 98 +++++++++
 tb/tb_req_grant_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and the 9-to-4 one-hot grant encoder
// used by the round-robin arbiter.
package arb_pkg;

  localparam int NREQ = 9;
  localparam int IDW  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Encoded index is 1..9 for bit 0..8; anything not exactly one-hot maps to 0.
  function automatic logic [IDW-1:0] onehot_to_id(input logic [NREQ-1:0] oh);
    logic [IDW-1:0] id;
    case (oh)
      9'h001:  id = 4'd1;
      9'h002:  id = 4'd2;
      9'h004:  id = 4'd3;
      9'h008:  id = 4'd4;
      9'h010:  id = 4'd5;
      9'h020:  id = 4'd6;
      9'h040:  id = 4'd7;
      9'h080:  id = 4'd8;
      9'h100:  id = 4'd9;
      default: id = 4'd0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request scanning from ptr_i
// upward with wrap from bit 8 to bit 0; returns a one-hot winner.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] win_o
);

  logic found;
  int   idx;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_grant_arbiter.sv
// Round-robin arbiter for 9 requesters with grant hold, rotating priority
// and a hold-timeout watchdog; grant and its encoded index are registered.
module req_grant_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CW       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic            timeout
);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic [NREQ-1:0] win;
  logic [IDW-1:0]  win_id;

  rr_pick u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win)
  );

  assign win_id = onehot_to_id(win);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && |req) begin
          gnt_d    = win;
          gnt_id_d = win_id;
          // The encoded index is already winner+1, which is the next pointer.
          ptr_d    = (win_id == IDW'(NREQ)) ? '0 : win_id;
          cnt_d    = CW'(1);
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (~|(req & gnt_q)) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (HOLD_MAX != 0 && cnt_q == CW'(HOLD_MAX)) begin
          gnt_d     = '0;
          gnt_id_d  = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Directed and randomized checks of req_grant_arbiter against a cycle-level
// behavioural model (owner index, pointer, hold length).
module tb_req_grant_arbiter;

  localparam int HOLD_MAX = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [8:0] req;
  logic [8:0] gnt;
  logic [3:0] gnt_id;
  logic       busy;
  logic       timeout;

  req_grant_arbiter #(.HOLD_MAX(HOLD_MAX), .CW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner is a requester number (-1 = none).
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  // Observation trackers for the directed scenarios.
  int prev_id;
  int run;
  int n_starts;
  int starts[64];
  int n_runs;
  int runs[64];
  int to_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (en && req != 9'd0) begin
        for (int k = 0; k < 9; k++) begin
          int cand;
          cand = (m_ptr + k) % 9;
          if (m_owner < 0 && req[cand]) m_owner = cand;
        end
        m_ptr  = (m_owner + 1) % 9;
        m_hold = 1;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
      m_to    = 1'b0;
    end else if (HOLD_MAX != 0 && m_hold == HOLD_MAX) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_hold++;
      m_to = 1'b0;
    end
  endtask

  task automatic clear_tracking();
    prev_id  = int'(gnt_id);
    run      = 0;
    n_starts = 0;
    n_runs   = 0;
    to_count = 0;
  endtask

  task automatic tick();
    logic [8:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner < 0) ? 9'd0 : (9'd1 << m_owner);
    check("gnt",     32'(gnt),     32'(eg));
    check("gnt_id",  32'(gnt_id),  (m_owner < 0) ? 32'd0 : 32'(m_owner + 1));
    check("busy",    32'(busy),    32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
    if (gnt_id != 4'd0 && prev_id == 0 && n_starts < 64) begin
      starts[n_starts] = int'(gnt_id);
      n_starts++;
    end
    if (gnt_id != 4'd0) run++;
    else if (run > 0) begin
      if (n_runs < 64) begin
        runs[n_runs] = run;
        n_runs++;
      end
      run = 0;
    end
    if (timeout) to_count++;
    prev_id = int'(gnt_id);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = 9'd0;

    // 1: reset for two cycles with no requests
    tick();
    tick();
    rst = 1'b0;
    clear_tracking();

    // 2: bits 0 and 8, grant order 1, 9 then wrap to 1
    req = 9'h101;
    repeat (5) tick();
    req = 9'h100;
    repeat (5) tick();
    req = 9'h000;
    repeat (2) tick();
    req = 9'h001;
    repeat (2) tick();
    check("s2_nstarts", 32'(n_starts), 32'd3);
    check("s2_first",   32'(starts[0]), 32'd1);
    check("s2_second",  32'(starts[1]), 32'd9);
    check("s2_wrap",    32'(starts[2]), 32'd1);
    req = 9'h000;
    repeat (2) tick();

    // 3: a single requester held 40 cycles hits the hold timeout twice
    clear_tracking();
    req = 9'h004;
    repeat (40) tick();
    req = 9'h000;
    repeat (2) tick();
    check("s3_nruns",    32'(n_runs),  32'd3);
    check("s3_run0",     32'(runs[0]), 32'd16);
    check("s3_run1",     32'(runs[1]), 32'd16);
    check("s3_run2",     32'(runs[2]), 32'd6);
    check("s3_timeouts", 32'(to_count), 32'd2);
    check("s3_id",       32'(starts[0]), 32'd3);

    // 4: all requesters, each owner drops after two cycles of grant
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_tracking();
    req = 9'h1FF;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (m_owner >= 0 && m_hold == 2) req[m_owner] = 1'b0;
      else req = 9'h1FF;
    end
    check("s4_nstarts", 32'(n_starts), 32'd11);
    for (int i = 0; i < 10; i++)
      check($sformatf("s4_rot%0d", i), 32'(starts[i]), 32'((i % 9) + 1));
    req = 9'h000;
    repeat (2) tick();

    // 5: enable gating of new grants only
    en  = 1'b0;
    req = 9'h010;
    repeat (3) tick();
    check("s5_blocked", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    check("s5_granted", 32'(gnt_id), 32'd5);
    en = 1'b0;
    repeat (3) tick();
    check("s5_kept", 32'(gnt_id), 32'd5);
    req = 9'h000;
    tick();
    check("s5_drop", 32'(gnt_id), 32'd0);
    en = 1'b1;
    tick();

    // 6: reset mid-grant clears the grant and the pointer
    req = 9'h040;
    tick();
    check("s6_pre", 32'(gnt_id), 32'd7);
    rst = 1'b1;
    tick();
    check("s6_rst", 32'(gnt), 32'd0);
    rst = 1'b0;
    req = 9'h0C0;
    tick();
    check("s6_ptr0", 32'(gnt_id), 32'd7);
    req = 9'h000;
    repeat (2) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(9, 0) < 3) req = 9'($urandom);
      en  = ($urandom_range(7, 0) != 0);
      rst = ($urandom_range(79, 0) == 0);
      tick();
    end
    rst = 1'b0;
    req = 9'h000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
